// File: rtl/step_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : step_input_conditioner
//  Purpose  : Synchronises and debounces the single-step push-button and the
//             two display-select slide switches. Produces a one-cycle step
//             pulse per accepted press, stable switch levels and an 8-bit
//             press counter for bring-up.
//  Ports    : CLK            - system clock, rising edge
//             Reset          - asynchronous active-high reset
//             Button_Raw     - raw step button (1 = pressed), asynchronous
//             Switch_Raw     - raw display-select switches, asynchronous
//             Step_Pulse     - one-cycle pulse per accepted press (registered)
//             Button_Level   - debounced button level
//             Switch_Status  - debounced switch levels, bits independent
//             Press_Count    - accepted presses modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
module step_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Button_Raw,
    input  logic [1:0] Switch_Raw,
    output logic       Step_Pulse,
    output logic       Button_Level,
    output logic [1:0] Switch_Status,
    output logic [7:0] Press_Count
);

    // Terminal count: a level is accepted on the edge that finds the counter
    // here while the sample still disagrees with the current level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers: bit 0 = button, bits 2:1 = switches
    // ------------------------------------------------------------------
    logic [2:0] sync_s1;
    logic [2:0] sync_s2;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync_s1 <= 3'b000;
            sync_s2 <= 3'b000;
        end else begin
            sync_s1 <= {Switch_Raw, Button_Raw};
            sync_s2 <= sync_s1;
        end
    end

    logic       btn_s2;
    logic [1:0] sw_s2;
    assign btn_s2 = sync_s2[0];
    assign sw_s2  = sync_s2[2:1];

    // ------------------------------------------------------------------
    // Button debounce FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    btn_state_t       btn_state;
    btn_state_t       btn_state_nx;
    logic [CNT_W-1:0] btn_cnt;
    logic [CNT_W-1:0] btn_cnt_nx;
    logic             pulse_nx;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            btn_state   <= IDLE;
            btn_cnt     <= '0;
            Step_Pulse  <= 1'b0;
            Press_Count <= 8'h00;
        end else begin
            btn_state  <= btn_state_nx;
            btn_cnt    <= btn_cnt_nx;
            Step_Pulse <= pulse_nx;
            // Counter advances on the same edge that raises Step_Pulse.
            if (pulse_nx) begin
                Press_Count <= Press_Count + 8'd1;
            end
        end
    end

    always_comb begin
        btn_state_nx = btn_state;
        btn_cnt_nx   = btn_cnt;
        pulse_nx     = 1'b0;
        case (btn_state)
            IDLE: begin
                if (btn_s2) begin
                    btn_state_nx = PRESS_WAIT;
                    btn_cnt_nx   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s2) begin
                    // Bounce: discard the partial count.
                    btn_state_nx = IDLE;
                    btn_cnt_nx   = '0;
                end else if (btn_cnt == CNT_LAST) begin
                    btn_state_nx = PRESSED;
                    btn_cnt_nx   = '0;
                    pulse_nx     = 1'b1;
                end else begin
                    btn_cnt_nx = btn_cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s2) begin
                    btn_state_nx = RELEASE_WAIT;
                    btn_cnt_nx   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s2) begin
                    // Release bounce: fall back to PRESSED without a new pulse.
                    btn_state_nx = PRESSED;
                    btn_cnt_nx   = '0;
                end else if (btn_cnt == CNT_LAST) begin
                    btn_state_nx = IDLE;
                    btn_cnt_nx   = '0;
                end else begin
                    btn_cnt_nx = btn_cnt + CNT_ONE;
                end
            end
            default: begin
                btn_state_nx = IDLE;
                btn_cnt_nx   = '0;
            end
        endcase
    end

    assign Button_Level = (btn_state == PRESSED) || (btn_state == RELEASE_WAIT);

    // ------------------------------------------------------------------
    // Switch filters: one counter per bit, a matching sample clears it
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sw
            logic [CNT_W-1:0] sw_cnt;
            logic             sw_level;

            always_ff @(posedge CLK or posedge Reset) begin
                if (Reset) begin
                    sw_cnt   <= '0;
                    sw_level <= 1'b0;
                end else if (sw_s2[gi] == sw_level) begin
                    sw_cnt <= '0;
                end else if (sw_cnt == CNT_LAST) begin
                    sw_level <= sw_s2[gi];
                    sw_cnt   <= '0;
                end else begin
                    sw_cnt <= sw_cnt + CNT_ONE;
                end
            end

            assign Switch_Status[gi] = sw_level;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_step_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_step_input_conditioner
//  Purpose  : Directed self-checking bench for step_input_conditioner with
//             DEBOUNCE_CYCLES=4. Expected pulses (cycle and count) are queued
//             when a press is driven and popped when Step_Pulse is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_step_input_conditioner;

    localparam int D = 4;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Button_Raw = 1'b0;
    logic [1:0] Switch_Raw = 2'b00;
    logic       Step_Pulse;
    logic       Button_Level;
    logic [1:0] Switch_Status;
    logic [7:0] Press_Count;

    step_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .Button_Raw   (Button_Raw),
        .Switch_Raw   (Switch_Raw),
        .Step_Pulse   (Step_Pulse),
        .Button_Level (Button_Level),
        .Switch_Status(Switch_Status),
        .Press_Count  (Press_Count)
    );

    always #5 CLK = ~CLK;

    // Rising edges seen so far; inputs change and outputs are sampled on
    // falling edges, so a value driven when cyc==N is first clocked at N+1.
    int cyc = 0;
    always @(posedge CLK) cyc++;

    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    int         exp_cyc_q[$];
    logic [7:0] exp_cnt_q[$];
    logic [7:0] model_cnt = 8'h00;
    int         mon_cyc;
    logic [7:0] mon_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drive a press and record when its pulse must appear and what count.
    task automatic press_push();
        Button_Raw = 1'b1;
        model_cnt  = model_cnt + 8'd1;
        exp_cyc_q.push_back(cyc + D + 2);
        exp_cnt_q.push_back(model_cnt);
    endtask

    // Scoreboard consumer: every high Step_Pulse cycle must match a queued press.
    always @(negedge CLK) begin
        if (!Reset && Step_Pulse === 1'b1) begin
            pulses++;
            if (exp_cyc_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_cyc = exp_cyc_q.pop_front();
                mon_cnt = exp_cnt_q.pop_front();
                check("pulse_cycle", cyc, mon_cyc);
                check("pulse_count", {24'd0, Press_Count}, {24'd0, mon_cnt});
            end
        end
    end

    int base_pulses;

    initial begin
        // ---------------- reset state ----------------
        tick(2);
        check("rst_pulse",  {31'd0, Step_Pulse},    32'd0);
        check("rst_level",  {31'd0, Button_Level},  32'd0);
        check("rst_switch", {30'd0, Switch_Status}, 32'd0);
        check("rst_count",  {24'd0, Press_Count},   32'd0);
        Reset = 1'b0;
        tick(3);

        // ---------------- clean press ----------------
        press_push();
        tick(D + 1);
        check("press_level_early", {31'd0, Button_Level}, 32'd0);
        tick(1);
        check("press_level", {31'd0, Button_Level}, 32'd1);
        tick(1);
        check("press_pulse_low", {31'd0, Step_Pulse}, 32'd0);
        tick(18);
        check("press_count", {24'd0, Press_Count}, 32'd1);
        Button_Raw = 1'b0;
        tick(D + 1);
        check("release_level_early", {31'd0, Button_Level}, 32'd1);
        tick(1);
        check("release_level", {31'd0, Button_Level}, 32'd0);
        tick(5);

        // ---------------- bounce on press ----------------
        Button_Raw = 1'b1; tick(1);
        Button_Raw = 1'b0; tick(1);
        Button_Raw = 1'b1; tick(1);
        Button_Raw = 1'b0; tick(1);
        press_push();
        tick(15);
        check("bounce_count", {24'd0, Press_Count}, 32'd2);
        Button_Raw = 1'b0;
        tick(10);

        // ---------------- release bounce ----------------
        press_push();
        tick(10);
        Button_Raw = 1'b0; tick(2);
        Button_Raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("relbounce_level", {31'd0, Button_Level}, 32'd1);
        end
        check("relbounce_count", {24'd0, Press_Count}, 32'd3);
        // A clean release from here only has the full latency if the FSM is in PRESSED.
        Button_Raw = 1'b0;
        tick(D + 1);
        check("relbounce_fall_early", {31'd0, Button_Level}, 32'd1);
        tick(1);
        check("relbounce_fall", {31'd0, Button_Level}, 32'd0);
        tick(5);

        // ---------------- switch filtering ----------------
        Switch_Raw = 2'b01; tick(D - 1);
        Switch_Raw = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("sw_glitch", {30'd0, Switch_Status}, 32'd0);
        end
        Switch_Raw = 2'b11;
        tick(D + 1);
        check("sw_early", {30'd0, Switch_Status}, 32'd0);
        tick(1);
        check("sw_set", {30'd0, Switch_Status}, 32'd3);
        Switch_Raw = 2'b10;
        tick(D + 2);
        check("sw_indep", {30'd0, Switch_Status}, 32'd2);

        // ---------------- counter wrap ----------------
        Reset = 1'b1;
        model_cnt = 8'h00;
        tick(2);
        check("wrap_rst_count", {24'd0, Press_Count}, 32'd0);
        Reset = 1'b0;
        tick(2);
        base_pulses = pulses;
        for (int i = 0; i < 256; i++) begin
            press_push();
            tick(D + 4);
            Button_Raw = 1'b0;
            tick(D + 4);
        end
        check("wrap_pulses", pulses - base_pulses, 32'd256);
        check("wrap_count", {24'd0, Press_Count}, 32'd0);

        // ---------------- reset mid-debounce ----------------
        press_push();
        tick(D + 4);
        Button_Raw = 1'b0;
        tick(D + 4);
        check("pre_rst_count", {24'd0, Press_Count}, 32'd1);
        Switch_Raw = 2'b11;
        tick(D + 4);
        Button_Raw = 1'b1;          // no pulse expected: reset lands in PRESS_WAIT
        tick(4);                    // FSM now in PRESS_WAIT with cnt=2
        Reset = 1'b1;
        #1;
        check("mid_rst_pulse",  {31'd0, Step_Pulse},    32'd0);
        check("mid_rst_level",  {31'd0, Button_Level},  32'd0);
        check("mid_rst_switch", {30'd0, Switch_Status}, 32'd0);
        check("mid_rst_count",  {24'd0, Press_Count},   32'd0);
        model_cnt = 8'h00;
        tick(2);
        Reset = 1'b0;
        model_cnt = model_cnt + 8'd1;
        exp_cyc_q.push_back(cyc + D + 2);
        exp_cnt_q.push_back(model_cnt);
        tick(12);
        check("post_rst_count", {24'd0, Press_Count}, 32'd1);
        check("missing_pulses", exp_cyc_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_input_conditioner.md
# step_input_conditioner

Input-side companion to the board's seven-segment display path. It conditions the raw single-step push-button and the two display-select slide switches. For each, it synchronises the input to the system clock and debounces it with a counter-based FSM. It outputs a clean one-cycle step pulse, used to advance the single-cycle CPU, plus stable switch levels, used to select the display page. An 8-bit press counter is provided for bring-up.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive identical synchronised samples required to accept a new level; legal range 2..65535.
- CNT_W, 16: width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Button_Raw  input  1  raw step button, high = pressed, asynchronous.
- Switch_Raw  input  2  raw display-select switches, asynchronous.
- Step_Pulse  output  1  high for exactly one CLK cycle per accepted press.
- Button_Level  output  1  debounced button level.
- Switch_Status  output  2  debounced switch levels; bits filtered independently.
- Press_Count  output  8  number of accepted presses, modulo 256.

## Operation
- Synchronisers: Button_Raw and each Switch_Raw bit each pass through two flops (s1, s2). Only s2 feeds the filters.
- Button FSM states:
  - IDLE: button released. If s2=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: if s2=0, go to IDLE with cnt=0 (bounce). Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to PRESSED and assert Step_Pulse next cycle. Otherwise cnt++.
  - PRESSED: if s2=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: if s2=1, go to PRESSED with cnt=0, no pulse. Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to IDLE. Otherwise cnt++.
- Button_Level is 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
- Step_Pulse is registered. It is 1 only in the cycle after the PRESS_WAIT→PRESSED transition. Holding the button never yields a second pulse.
- Press_Count increments on the same edge that sets Step_Pulse. It wraps 255→0.
- Switch filter, per bit:
  - If s2==Switch_Status[i], cnt_i=0.
  - Else, if cnt_i==DEBOUNCE_CYCLES-1, Switch_Status[i]<=s2 and cnt_i=0.
  - Else, cnt_i++.
  - A single matching sample discards the partial count.
- Bits change independently. Both bits may update on the same edge.

## Timing
- Reset values:
  - s1 and s2 are 0.
  - FSM is IDLE; all counters are 0.
  - Step_Pulse=0, Button_Level=0, Switch_Status=2'b00, Press_Count=8'h00.
- Press latency: Button_Raw goes high before edge 0 and stays stable. s2=1 after edge 1. Step_Pulse and Button_Level go high after edge DEBOUNCE_CYCLES+1. Step_Pulse goes low after edge DEBOUNCE_CYCLES+2.
- Release latency: Button_Level falls after edge DEBOUNCE_CYCLES+1, counted from the first released sample at raw edge 0.
- Switch latency: same as press latency, DEBOUNCE_CYCLES+1 edges after the raw change.
- Glitch rejection: a raw glitch shorter than DEBOUNCE_CYCLES cycles, measured at s2, never changes any output.
- Reset mid-operation: all state returns to reset values immediately, with no pulse emitted. If the button is held through reset release, the full debounce runs again and one pulse is produced.
- Step_Pulse and Press_Count never change on the same edge as Reset deassertion.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Clean press: Button_Raw 0→1 before edge 0, held 20 cycles, then released. Step_Pulse is high only after edge 5. Button_Level is high from edge 5. Press_Count=1. Button_Level falls 5 edges after release.
- Bounce on press: Button_Raw toggles 1,0,1,0 per cycle, then holds 1. Exactly one Step_Pulse, 5 edges after the final rise. Press_Count=1.
- Release bounce: while pressed, Button_Raw goes 0 for 2 cycles then back to 1. No pulse. Button_Level stays 1. FSM returns to PRESSED.
- Switch filtering: Switch_Raw=2'b01 for 3 cycles, then 2'b00. Switch_Status stays 00. Then Switch_Raw=2'b11 held. Switch_Status becomes 11 after edge 5.
- Counter wrap: 256 clean presses give Press_Count 8'hFF→8'h00 on the 256th, with exactly 256 Step_Pulse cycles.
- Reset mid-debounce: assert Reset in PRESS_WAIT with cnt=2. All outputs are 0 immediately. With the button still held after deassertion, one pulse occurs 5 edges later.
